// File: rtl/mult_ctrl.sv
// mult_ctrl: sequencing controller for the shift-add multiplier.
// Drives the accumulator's Load/Sh/Ad commands from the current multiplier
// bit, counts completed shifts and reports completion with a level
// start/done handshake.
module mult_ctrl #(
   parameter int unsigned N  = 16,
   parameter int unsigned CW = 5
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          St,
   input  logic          M,
   output logic          Load,
   output logic          Sh,
   output logic          Ad,
   output logic          Busy,
   output logic          Done,
   output logic [CW-1:0] Cnt
);

   typedef enum logic [1:0] {
      IDLE,
      ADD_CHK,
      SHIFT,
      DONE
   } state_t;

   // Shift count value that marks the final iteration
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t state;

   logic last_shift;
   assign last_shift = (Cnt == LAST);

   // State and shift counter; reset returns to IDLE with a cleared count
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
         Cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (St) begin
                  Cnt   <= '0;
                  state <= ADD_CHK;
               end
            end
            ADD_CHK: begin
               if (M) begin
                  state <= SHIFT;
               end else begin
                  Cnt   <= Cnt + CW'(1);
                  state <= last_shift ? DONE : ADD_CHK;
               end
            end
            SHIFT: begin
               Cnt   <= Cnt + CW'(1);
               state <= last_shift ? DONE : ADD_CHK;
            end
            DONE: begin
               if (!St) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Mealy command decode; everything is forced low while reset is held so
   // that a start request during reset cannot leak out as a Load
   always_comb begin
      Load = 1'b0;
      Sh   = 1'b0;
      Ad   = 1'b0;
      Busy = 1'b0;
      Done = 1'b0;
      if (!Rst) begin
         unique case (state)
            IDLE: begin
               Load = St;
               Busy = St;
            end
            ADD_CHK: begin
               Busy = 1'b1;
               if (M) begin
                  Ad = 1'b1;
               end else begin
                  Sh = 1'b1;
               end
            end
            SHIFT: begin
               Busy = 1'b1;
               Sh   = 1'b1;
            end
            DONE: begin
               Done = 1'b1;
            end
            default: begin
               Busy = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_ctrl.sv
// tb_mult_ctrl: drives the controller together with a behavioural
// accumulator and checks every cycle's command against the command list
// implied by the multiplier bits, plus the final product.
module tb_mult_ctrl;

   localparam int N  = 16;
   localparam int CW = 5;

   localparam logic [2:0] C_NONE = 3'b000;
   localparam logic [2:0] C_LOAD = 3'b100;
   localparam logic [2:0] C_AD   = 3'b010;
   localparam logic [2:0] C_SH   = 3'b001;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          St;
   logic          M;
   logic          Load;
   logic          Sh;
   logic          Ad;
   logic          Busy;
   logic          Done;
   logic [CW-1:0] Cnt;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   logic [2*N:0]  acc = '0;
   logic [N-1:0]  mcand = '0;
   logic [N-1:0]  mplier = '0;

   mult_ctrl #(.N(N), .CW(CW)) dut (
      .Clk  (Clk),
      .Rst  (Rst),
      .St   (St),
      .M    (M),
      .Load (Load),
      .Sh   (Sh),
      .Ad   (Ad),
      .Busy (Busy),
      .Done (Done),
      .Cnt  (Cnt)
   );

   always #5 Clk = ~Clk;

   // Behavioural accumulator: acts on the commands present at each edge
   always @(posedge Clk) begin
      if (Load)
         acc <= {{(N+1){1'b0}}, mplier};
      else if (Ad)
         acc <= {acc[2*N:N] + {1'b0, mcand}, acc[N-1:0]};
      else if (Sh)
         acc <= acc >> 1;
   end

   assign M = acc[0];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
         $error("check %s", tag);
      end
   endtask

   // One multiply. hold keeps St high through Done; noise toggles St at
   // random while busy; abort_at >= 0 asserts Rst mid-cycle at that step.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit hold, input bit noise, input int abort_at);
      logic [2:0]  exp_q[$];
      logic [31:0] prod;
      int          shifts;
      exp_q  = {};
      exp_q.push_back(C_LOAD);
      for (int i = 0; i < N; i++) begin
         if (b[i]) exp_q.push_back(C_AD);
         exp_q.push_back(C_SH);
      end
      prod   = 32'(a) * 32'(b);
      shifts = 0;
      mcand  = a;
      mplier = b;
      for (int k = 0; k < exp_q.size(); k++) begin
         @(negedge Clk);
         if (k == 0)      St = 1'b1;
         else if (hold)   St = 1'b1;
         else if (noise)  St = 1'($urandom % 2);
         else             St = 1'b0;
         #1;
         chk($sformatf("cmd[%0d]", k), 64'({Load, Ad, Sh}), 64'(exp_q[k]));
         chk($sformatf("busy[%0d]", k), 64'(Busy), 64'(1));
         chk($sformatf("done[%0d]", k), 64'(Done), 64'(0));
         if (k > 0) chk($sformatf("cnt[%0d]", k), 64'(Cnt), 64'(shifts));
         if (exp_q[k] == C_SH) shifts++;
         if (k == abort_at) begin
            #2 Rst = 1'b1;
            #1;
            chk("rst_cmd", 64'({Load, Ad, Sh}), 64'(C_NONE));
            chk("rst_done_busy", 64'({Done, Busy}), 64'(0));
            chk("rst_cnt", 64'(Cnt), 64'(0));
            @(negedge Clk);
            Rst = 1'b0;
            St  = 1'b0;
            #1;
            chk("post_rst_cmd", 64'({Load, Ad, Sh, Busy, Done}), 64'(0));
            @(negedge Clk);
            #1;
            chk("post_rst_idle", 64'({Load, Ad, Sh, Busy, Done}), 64'(0));
            chk("post_rst_cnt", 64'(Cnt), 64'(0));
            return;
         end
      end
      @(negedge Clk);
      St = hold;
      #1;
      chk("done_flag", 64'(Done), 64'(1));
      chk("done_cmd", 64'({Load, Ad, Sh, Busy}), 64'(0));
      chk("done_cnt", 64'(Cnt), 64'(N));
      chk("product", 64'(acc[2*N-1:0]), 64'(prod));
      if (hold) begin
         for (int j = 0; j < 3; j++) begin
            @(negedge Clk);
            #1;
            chk("hold_done", 64'(Done), 64'(1));
            chk("hold_cmd", 64'({Load, Ad, Sh, Busy}), 64'(0));
         end
         @(negedge Clk);
         St = 1'b0;
         #1;
         chk("release_done", 64'(Done), 64'(1));
      end
      @(negedge Clk);
      St = 1'b0;
      #1;
      chk("idle_after", 64'({Load, Ad, Sh, Busy, Done}), 64'(0));
   endtask

   initial begin
      Rst = 1'b1;
      St  = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      chk("reset_cmd", 64'({Load, Ad, Sh}), 64'(C_NONE));
      chk("reset_busy_done", 64'({Busy, Done}), 64'(0));
      chk("reset_cnt", 64'(Cnt), 64'(0));
      St  = 1'b0;
      @(negedge Clk);
      Rst = 1'b0;
      #1;
      chk("idle_cmd", 64'({Load, Ad, Sh, Busy, Done}), 64'(0));

      run_op(16'(($urandom % 65535) + 1), 16'h0000, 1'b0, 1'b0, -1);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, -1);
      run_op(16'h0005, 16'h0003, 1'b0, 1'b0, -1);
      run_op(16'h1234, 16'h8001, 1'b1, 1'b0, -1);
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 6);
      run_op(16'h00A5, 16'h5A5A, 1'b0, 1'b1, -1);
      for (int r = 0; r < 6; r++) begin
         run_op(16'($urandom), 16'($urandom), 1'(r == 2), 1'($urandom % 2), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
